fetch_request_unit: RTL
=======================

// Module: fetch_request_unit
// PURPOSE
// - Parametrised PC + memory-request sequencer for the single-cycle datapath.
// - Owns the PC register and issues imem/dmem requests.
// - Strobes regfile write and retire on hit completion; latches halt.
// - Adds a data-wait timeout monitor and a retired-instruction counter.
// - Sits between control_unit/hazard_unit and the cache interface (datapath_cache_if).
// PARAMETERS
// - PC_W      32  PC / address width
// - PC_INIT   0   PC value after reset (bits[1:0] must be 0)
// - CNT_W     32  retired-instruction counter width
// - TIMEOUT   64  dmem wait cycles before timeout_err; 0 disables the monitor
// PORTS
// - CLK        in   1      clock, rising edge
// - nRST       in   1      asynchronous reset, active-low
// - ihit       in   1      imem hit; instruction on imemload valid this cycle
// - dhit       in   1      dmem hit; load data / store done this cycle
// - npc        in   PC_W   next PC chosen by datapath mux (PC4/branch/JR/J)
// - cu_dREN    in   1      decoded: instruction reads dmem
// - cu_dWEN    in   1      decoded: instruction writes dmem
// - cu_rWEN    in   1      decoded: instruction writes regfile
// - cu_halt    in   1      decoded: HALT opcode
// - PC         out  PC_W   current PC
// - imemREN    out  1      instruction fetch request
// - dmemREN    out  1      data read request
// - dmemWEN    out  1      data write request
// - rWEN       out  1      regfile write strobe (combinational, one cycle)
// - retire     out  1      one-cycle pulse: instruction completes, PC updates next edge
// - halt       out  1      sticky halt
// - instr_cnt  out  CNT_W  retired-instruction count
// - timeout_err out 1      sticky: dmem wait reached TIMEOUT
// BEHAVIOUR
// - Reset (async, any state):
//   - FETCH state; PC=PC_INIT; halt=0; instr_cnt=0; timeout_err=0; wait counter=0.
//   - Latched dREN/dWEN cleared; imemREN=1 once nRST deasserts; all other outputs 0.
// - FETCH: imemREN=1, dmemREN=dmemWEN=0.
//   - ihit & cu_halt -> HALTED; PC not updated; no retire; no rWEN.
//   - ihit & (cu_dREN|cu_dWEN) -> DATA next edge:
//     latch dREN, dWEN, rWEN-intent; clear wait counter; PC held.
//   - ihit, no mem op:
//     rWEN=cu_rWEN and retire=1 this cycle; PC<=npc; instr_cnt+1 next edge.
//   - dhit ignored in FETCH, including when it coincides with ihit.
// - DATA: imemREN=0; dmemREN/dmemWEN = latched values (both may not be 1; REN wins).
//   - dhit: rWEN = latched rWEN-intent & latched dREN (stores never write regfile);
//     retire=1; PC<=npc; instr_cnt+1; -> FETCH next edge.
//   - no dhit: wait counter +1, saturating.
//   - Counter == TIMEOUT-1 without dhit (TIMEOUT>0) -> timeout_err<=1 (sticky).
//     Request stays asserted; state unchanged.
//   - ihit ignored in DATA.
// - HALTED: imemREN=dmemREN=dmemWEN=rWEN=retire=0; halt=1.
//   - PC and instr_cnt frozen until reset.
// - PC always stored with bits[1:0]=2'b00 (npc[1:0] discarded).
// - PC wraps modulo 2^PC_W; instr_cnt wraps modulo 2^CNT_W.
// - Single-cycle latency: ALU op retires in its ihit cycle.
//   Load/store retires in its dhit cycle, at minimum one cycle after ihit.
// STRUCTURE
// - Add to control_sel_pkg: typedef enum logic [1:0] {REQ_FETCH, REQ_DATA, REQ_HALT} req_state_t.
// - PC word type from cpu_types_pkg (word_t) when PC_W==32.
// - Sub-module req_timeout_ctr (params W, TIMEOUT; clr, inc -> expired).
//   Instantiated once for the DATA-wait monitor.
// - State register, PC register, counters: always_ff on CLK / negedge nRST.
//   Next-state and outputs: always_comb.
// TESTING
// - Reset mid-DATA (nRST low while dmemREN=1):
//   -> PC=PC_INIT, dmemREN=0, instr_cnt=0, imemREN=1 after release.
// - ADD (cu_rWEN=1) with npc=0x4 on ihit:
//   -> rWEN=1 and retire=1 same cycle; PC=0x4, instr_cnt=1 next edge.
// - LW: ihit, then dhit after 3 cycles:
//   -> dmemREN=1 for 3 cycles then the dhit cycle; rWEN=1 only on dhit; PC=npc after.
// - SW with cu_rWEN=1 forced:
//   -> dmemWEN=1 until dhit; rWEN stays 0; retire on dhit.
// - TIMEOUT=4, DATA with no dhit for 6 cycles:
//   -> timeout_err rises after 4th wait cycle, dmemREN still 1; a later dhit completes normally.
// - HALT with PC=0x20 on ihit:
//   -> halt=1, imemREN=0, PC stays 0x20 forever.
//   Further ihit/dhit cause no change; ihit&dhit in FETCH acts as ihit only.

Source files
------------

// File: rtl/fetch_request_unit_pkg.sv
// Shared types for the fetch/memory request sequencer.
package fetch_request_unit_pkg;

    typedef enum logic [1:0] {REQ_FETCH, REQ_DATA, REQ_HALT} req_state_t;

    typedef logic [31:0] word_t;

    // Wait counter only has to reach TIMEOUT-1.
    function automatic int tmo_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/req_timeout_ctr.sv
// Saturating wait counter; flags the cycle in which the wait reaches TIMEOUT.
module req_timeout_ctr #(
    parameter int W       = 6,
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                   cnt <= '0;
        else if (clr)                cnt <= '0;
        else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && inc && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_request_unit.sv
// PC register and imem/dmem request sequencer with retire strobe, sticky halt,
// retired-instruction counter and data-wait timeout monitor.
module fetch_request_unit
    import fetch_request_unit_pkg::*;
#(
    parameter int              PC_W    = 32,
    parameter logic [PC_W-1:0] PC_INIT = '0,
    parameter int              CNT_W   = 32,
    parameter int              TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [PC_W-1:0]  npc,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_rWEN,
    input  logic             cu_halt,
    output logic [PC_W-1:0]  PC,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             rWEN,
    output logic             retire,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             timeout_err
);
    localparam int TW = tmo_width(TIMEOUT);

    req_state_t state, nstate;
    logic       dren_q, dwen_q, rwen_q;
    logic       latch_mem, tmo_exp;

    always_comb begin
        nstate    = state;
        imemREN   = 1'b0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        rWEN      = 1'b0;
        retire    = 1'b0;
        latch_mem = 1'b0;
        case (state)
            REQ_FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (cu_halt) begin
                        nstate = REQ_HALT;
                    end else if (cu_dREN || cu_dWEN) begin
                        nstate    = REQ_DATA;
                        latch_mem = 1'b1;
                    end else begin
                        rWEN   = cu_rWEN;
                        retire = 1'b1;
                    end
                end
            end
            REQ_DATA: begin
                // Read wins if both were decoded; stores never write the regfile.
                dmemREN = dren_q;
                dmemWEN = dwen_q & ~dren_q;
                if (dhit) begin
                    rWEN   = rwen_q & dren_q;
                    retire = 1'b1;
                    nstate = REQ_FETCH;
                end
            end
            default: ;
        endcase
    end

    assign halt = (state == REQ_HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= REQ_FETCH;
            PC          <= PC_INIT;
            instr_cnt   <= '0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            rwen_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= nstate;
            if (latch_mem) begin
                dren_q <= cu_dREN;
                dwen_q <= cu_dWEN;
                rwen_q <= cu_rWEN;
            end
            if (retire) begin
                PC        <= {npc[PC_W-1:2], 2'b00};
                instr_cnt <= instr_cnt + 1'b1;
            end
            if (tmo_exp) timeout_err <= 1'b1;
        end
    end

    req_timeout_ctr #(.W(TW), .TIMEOUT(TIMEOUT)) u_wait_ctr (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (latch_mem),
        .inc     (state == REQ_DATA && !dhit),
        .expired (tmo_exp)
    );

endmodule
